// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg: shared types and constants for the DMA channel scheduler.
//   dma_sched_state_t   - scheduler FSM state encoding
//   DMA_SCHED_MAX_BURST - default maximum beats per engine burst
//   DMA_SCHED_BEATS_W   - width of a burst-length field for the default burst size
//   dma_sched_beats_w() - same width for an arbitrary burst size
package dma_sched_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StDone  = 2'd3
    } dma_sched_state_t;

    localparam int unsigned DMA_SCHED_MAX_BURST = 16;
    localparam int unsigned DMA_SCHED_BEATS_W   = $clog2(DMA_SCHED_MAX_BURST) + 1;

    // Enough bits to hold the value max_burst itself (1..max_burst).
    function automatic int unsigned dma_sched_beats_w(input int unsigned max_burst);
        return $clog2(max_burst) + 1;
    endfunction

endpackage

// File: rtl/dma_channel_scheduler_if.sv
// dma_channel_scheduler_if: burst command / completion bundle between the scheduler and
// the DMA engine datapath.
//   eng_valid, eng_src, eng_dst, eng_beats : command, scheduler -> engine
//   eng_ready                              : command accept, engine -> scheduler
//   eng_done                               : burst-complete pulse, engine -> scheduler
//   eng_err                                : burst error, qualified by eng_done
//                                            (only when DMA_SCHED_ERR_EN is defined)
// Modports: master (scheduler side), slave (engine side).
interface dma_channel_scheduler_if
    import dma_sched_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BEATS_W = DMA_SCHED_BEATS_W
);
    logic               eng_valid;
    logic               eng_ready;
    logic [ADDR_W-1:0]  eng_src;
    logic [ADDR_W-1:0]  eng_dst;
    logic [BEATS_W-1:0] eng_beats;
    logic               eng_done;
`ifdef DMA_SCHED_ERR_EN
    logic               eng_err;

    modport master (
        output eng_valid, eng_src, eng_dst, eng_beats,
        input  eng_ready, eng_done, eng_err
    );
    modport slave (
        input  eng_valid, eng_src, eng_dst, eng_beats,
        output eng_ready, eng_done, eng_err
    );
`else
    modport master (
        output eng_valid, eng_src, eng_dst, eng_beats,
        input  eng_ready, eng_done
    );
    modport slave (
        input  eng_valid, eng_src, eng_dst, eng_beats,
        output eng_ready, eng_done
    );
`endif
endinterface

// File: rtl/dma_rr_arbiter.sv
// dma_rr_arbiter: combinational round-robin pick among NUM_CH requesters.
//   req    in  NUM_CH : request vector
//   rr_ptr in  PTR_W  : highest-priority channel this round
//   gnt    out NUM_CH : one-hot grant (all zero when no request)
//   idx    out PTR_W  : binary index of the granted channel
//   valid  out 1      : at least one request present
module dma_rr_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned PTR_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [PTR_W-1:0]  rr_ptr,
    output logic [NUM_CH-1:0] gnt,
    output logic [PTR_W-1:0]  idx,
    output logic              valid
);

    always_comb begin : p_arb
        logic [PTR_W-1:0] c;
        c     = '0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        // Walk channels starting at rr_ptr, wrapping; first requester wins.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            c = PTR_W'((32'(rr_ptr) + i) % NUM_CH);
            if (!valid && req[c]) begin
                valid  = 1'b1;
                gnt[c] = 1'b1;
                idx    = c;
            end
        end
    end

endmodule

// File: rtl/dma_channel_scheduler.sv
// dma_channel_scheduler: shares one DMA engine among NUM_CH channels. Grants requests
// round-robin, latches the winner's descriptor and splits the transfer into bursts of at
// most MAX_BURST beats, each issued over a valid/ready handshake and retired by eng_done.
//   clock, reset          : single clock, synchronous active-high reset
//   ch_req                : per-channel level request
//   ch_src, ch_dst, ch_len: packed per-channel descriptors (slice i = channel i)
//   ch_ack, ch_done       : per-channel one-cycle pulses (accepted / complete)
//   ch_err                : per-channel abort pulse alongside ch_done (DMA_SCHED_ERR_EN)
//   busy                  : scheduler not idle
//   eng                   : engine command/completion interface (master side)
// Optional feature macro: DMA_SCHED_ERR_EN (engine error aborts the transfer).
module dma_channel_scheduler
    import dma_sched_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned MAX_BURST = DMA_SCHED_MAX_BURST
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*ADDR_W-1:0] ch_src,
    input  logic [NUM_CH*ADDR_W-1:0] ch_dst,
    input  logic [NUM_CH*LEN_W-1:0]  ch_len,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic [NUM_CH-1:0]        ch_done,
`ifdef DMA_SCHED_ERR_EN
    output logic [NUM_CH-1:0]        ch_err,
`endif
    output logic                     busy,
    dma_channel_scheduler_if.master  eng
);

    localparam int unsigned PTR_W   = $clog2(NUM_CH);
    localparam int unsigned BEATS_W = dma_sched_beats_w(MAX_BURST);

    dma_sched_state_t    state_q, state_d;
    logic [PTR_W-1:0]    rr_ptr_q, gidx_q;
    logic [NUM_CH-1:0]   gnt_q, ack_q;
    logic [ADDR_W-1:0]   cur_src_q, cur_dst_q;
    logic [LEN_W-1:0]    rem_q;

    logic [NUM_CH-1:0]   arb_gnt;
    logic [PTR_W-1:0]    arb_idx;
    logic                arb_valid;
    logic [ADDR_W-1:0]   sel_src, sel_dst;
    logic [LEN_W-1:0]    sel_len;
    logic [BEATS_W-1:0]  burst_beats;
    logic                abort;

    dma_rr_arbiter #(
        .NUM_CH (NUM_CH),
        .PTR_W  (PTR_W)
    ) u_arb (
        .req    (ch_req),
        .rr_ptr (rr_ptr_q),
        .gnt    (arb_gnt),
        .idx    (arb_idx),
        .valid  (arb_valid)
    );

    always_comb begin
        sel_src = '0;
        sel_dst = '0;
        sel_len = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_gnt[i]) begin
                sel_src = ch_src[i*ADDR_W +: ADDR_W];
                sel_dst = ch_dst[i*ADDR_W +: ADDR_W];
                sel_len = ch_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Burst size is derived from rem_q, which only changes on eng_done, so the command
    // is stable across ISSUE and the same value is retired in WAIT.
    always_comb begin
        if (rem_q >= LEN_W'(MAX_BURST)) begin
            burst_beats = BEATS_W'(MAX_BURST);
        end else begin
            burst_beats = BEATS_W'(rem_q);
        end
    end

`ifdef DMA_SCHED_ERR_EN
    assign abort = eng.eng_err;
`else
    assign abort = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (arb_valid) begin
                    state_d = (sel_len == '0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (eng.eng_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (eng.eng_done) begin
                    state_d = (abort || rem_q == LEN_W'(burst_beats)) ? StDone : StIssue;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Descriptor, grant and round-robin registers.
`ifdef DMA_SCHED_ERR_EN
    logic err_q;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            gidx_q    <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            cur_src_q <= '0;
            cur_dst_q <= '0;
            rem_q     <= '0;
`ifdef DMA_SCHED_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            ack_q <= '0;
            unique case (state_q)
                StIdle: begin
                    if (arb_valid) begin
                        ack_q     <= arb_gnt;
                        gnt_q     <= arb_gnt;
                        gidx_q    <= arb_idx;
                        cur_src_q <= sel_src;
                        cur_dst_q <= sel_dst;
                        rem_q     <= sel_len;
`ifdef DMA_SCHED_ERR_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                StWait: begin
                    if (eng.eng_done) begin
                        rem_q     <= rem_q - LEN_W'(burst_beats);
                        cur_src_q <= cur_src_q + ADDR_W'(burst_beats);
                        cur_dst_q <= cur_dst_q + ADDR_W'(burst_beats);
`ifdef DMA_SCHED_ERR_EN
                        if (abort) begin
                            err_q <= 1'b1;
                        end
`endif
                    end
                end
                StDone: begin
                    rr_ptr_q <= (gidx_q == PTR_W'(NUM_CH - 1)) ? '0 : gidx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs: decoded from state and registers only.
    always_comb begin
        eng.eng_valid = (state_q == StIssue);
        eng.eng_src   = (state_q == StIssue) ? cur_src_q : '0;
        eng.eng_dst   = (state_q == StIssue) ? cur_dst_q : '0;
        eng.eng_beats = (state_q == StIssue) ? burst_beats : '0;
        ch_ack        = ack_q;
        ch_done       = (state_q == StDone) ? gnt_q : '0;
        busy          = (state_q != StIdle);
`ifdef DMA_SCHED_ERR_EN
        ch_err        = (state_q == StDone && err_q) ? gnt_q : '0;
`endif
    end

endmodule

// File: tb/tb_dma_channel_scheduler.sv
// Self-checking bench for dma_channel_scheduler with a scoreboard of expected acks,
// engine commands and completions, plus a simple engine responder.
module tb_dma_channel_scheduler;
    import dma_sched_pkg::*;

    localparam int unsigned NUM_CH  = 4;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned BEATS_W = 5;

    typedef struct packed {
        logic [31:0] src;
        logic [31:0] dst;
        logic [4:0]  beats;
    } cmd_t;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH*ADDR_W-1:0] ch_src;
    logic [NUM_CH*ADDR_W-1:0] ch_dst;
    logic [NUM_CH*LEN_W-1:0]  ch_len;
    logic [NUM_CH-1:0]        ch_ack;
    logic [NUM_CH-1:0]        ch_done;
`ifdef DMA_SCHED_ERR_EN
    logic [NUM_CH-1:0]        ch_err;
`endif
    logic                     busy;

    dma_channel_scheduler_if #(.ADDR_W(ADDR_W), .BEATS_W(BEATS_W)) eng_if ();

    dma_channel_scheduler #(
        .NUM_CH    (NUM_CH),
        .ADDR_W    (ADDR_W),
        .LEN_W     (LEN_W),
        .MAX_BURST (16)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ch_req  (ch_req),
        .ch_src  (ch_src),
        .ch_dst  (ch_dst),
        .ch_len  (ch_len),
        .ch_ack  (ch_ack),
        .ch_done (ch_done),
`ifdef DMA_SCHED_ERR_EN
        .ch_err  (ch_err),
`endif
        .busy    (busy),
        .eng     (eng_if)
    );

    always #5 clock = ~clock;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   eng_lat  = 0;
    bit   err_inject = 1'b0;

    int   exp_ack[$];
    cmd_t exp_cmd[$];
    int   exp_done[$];
    bit   exp_err[$];

    // Engine responder: pulses eng_done eng_lat cycles after each accepted command.
    initial begin : engine
        eng_if.eng_done = 1'b0;
`ifdef DMA_SCHED_ERR_EN
        eng_if.eng_err  = 1'b0;
`endif
        forever begin
            @(negedge clock);
            if (!reset && eng_if.eng_valid && eng_if.eng_ready) begin
                @(posedge clock);
                repeat (eng_lat) @(posedge clock);
                #1;
                eng_if.eng_done = 1'b1;
`ifdef DMA_SCHED_ERR_EN
                eng_if.eng_err  = err_inject;
`endif
                err_inject = 1'b0;
                @(posedge clock);
                #1;
                eng_if.eng_done = 1'b0;
`ifdef DMA_SCHED_ERR_EN
                eng_if.eng_err  = 1'b0;
`endif
            end
        end
    end

    // Scoreboard monitor, sampled mid-cycle.
    always @(negedge clock) begin : monitor
        logic [3:0] oh;
        int   e;
        cmd_t got, want;
        if (!reset) begin
            if (ch_ack != '0) begin
                n_checks++;
                if (exp_ack.size() == 0) begin
                    n_fail++;
                    $display("FAIL ack_unexpected: got %b want none", ch_ack);
                end else begin
                    e  = exp_ack.pop_front();
                    oh = 4'b0001 << e;
                    if (ch_ack !== oh) begin
                        n_fail++;
                        $display("FAIL ack: got %b want %b", ch_ack, oh);
                    end
                end
            end
            if (eng_if.eng_valid && eng_if.eng_ready) begin
                got.src   = eng_if.eng_src;
                got.dst   = eng_if.eng_dst;
                got.beats = eng_if.eng_beats;
                n_checks++;
                if (exp_cmd.size() == 0) begin
                    n_fail++;
                    $display("FAIL cmd_unexpected: got src=%h dst=%h beats=%0d want none",
                             got.src, got.dst, got.beats);
                end else begin
                    want = exp_cmd.pop_front();
                    if (got !== want) begin
                        n_fail++;
                        $display("FAIL cmd: got src=%h dst=%h beats=%0d want src=%h dst=%h beats=%0d",
                                 got.src, got.dst, got.beats, want.src, want.dst, want.beats);
                    end
                end
            end
            if (ch_done != '0) begin
                n_checks++;
                if (exp_done.size() == 0) begin
                    n_fail++;
                    $display("FAIL done_unexpected: got %b want none", ch_done);
                end else begin
                    e  = exp_done.pop_front();
                    oh = 4'b0001 << e;
                    if (ch_done !== oh) begin
                        n_fail++;
                        $display("FAIL done: got %b want %b", ch_done, oh);
                    end
`ifdef DMA_SCHED_ERR_EN
                    n_checks++;
                    if (ch_err !== (exp_err.pop_front() ? oh : 4'b0000)) begin
                        n_fail++;
                        $display("FAIL err_flag: got %b with done %b", ch_err, oh);
                    end
`else
                    void'(exp_err.pop_front());
`endif
                end
            end
        end
    end

    task automatic push_xfer(input int ch, input logic [31:0] s, input logic [31:0] d,
                             input int unsigned len, input bit err_first);
        int unsigned rem, b;
        cmd_t c;
        rem = len;
        exp_ack.push_back(ch);
        while (rem != 0) begin
            b = (rem > 16) ? 16 : rem;
            c.src = s; c.dst = d; c.beats = 5'(b);
            exp_cmd.push_back(c);
            rem = rem - b;
            s   = s + b;
            d   = d + b;
            if (err_first) rem = 0;
        end
        exp_done.push_back(ch);
        exp_err.push_back(err_first);
    endtask

    task automatic set_desc(input int ch, input logic [31:0] s, input logic [31:0] d,
                            input logic [15:0] len);
        ch_src[ch*32 +: 32] = s;
        ch_dst[ch*32 +: 32] = d;
        ch_len[ch*16 +: 16] = len;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ch_req = '0;
        eng_if.eng_ready = 1'b1;
        eng_lat = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_ack.delete(); exp_cmd.delete(); exp_done.delete(); exp_err.delete();
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            #2;
            if (exp_ack.size() == 0 && exp_cmd.size() == 0 && exp_done.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_acks(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock);
            #2;
            if (exp_ack.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ch_req = '0; ch_src = '0; ch_dst = '0; ch_len = '0;
        eng_if.eng_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if ({ch_ack, ch_done, eng_if.eng_valid, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ack=%b done=%b valid=%b busy=%b want all 0",
                     ch_ack, ch_done, eng_if.eng_valid, busy);
        end
        n_checks++;
        if ({eng_if.eng_src, eng_if.eng_dst, eng_if.eng_beats} !== '0) begin
            n_fail++;
            $display("FAIL reset_cmd: got src=%h dst=%h beats=%0d want 0",
                     eng_if.eng_src, eng_if.eng_dst, eng_if.eng_beats);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_burst();
        bit ok;
        do_reset();
        set_desc(1, 32'h100, 32'h200, 16'd8);
        push_xfer(1, 32'h100, 32'h200, 8, 1'b0);
        ch_req = 4'b0010;
        @(posedge clock);
        #1;
        n_checks++;
        if (ch_ack !== 4'b0010 || eng_if.eng_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ack_timing: got ack=%b valid=%b want 0010/1",
                     ch_ack, eng_if.eng_valid);
        end
        ch_req = '0;
        wait_drain(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_drain: got timeout want completion"); end
        // rr_ptr is now 2: with ch0 and ch2 both requesting, ch2 must win first.
        set_desc(0, 32'h700, 32'h800, 16'd1);
        set_desc(2, 32'h900, 32'hA00, 16'd1);
        push_xfer(2, 32'h900, 32'hA00, 1, 1'b0);
        push_xfer(0, 32'h700, 32'h800, 1, 1'b0);
        ch_req = 4'b0101;
        wait_acks(50, ok);
        ch_req = '0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rr_acks: got timeout want two acks"); end
        wait_drain(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rr_drain: got timeout want completion"); end
    endtask

    task automatic test_split();
        bit ok;
        do_reset();
        eng_lat = 2;
        set_desc(0, 32'h0, 32'h1000, 16'd40);
        push_xfer(0, 32'h0, 32'h1000, 40, 1'b0);
        ch_req = 4'b0001;
        @(posedge clock);
        #1;
        ch_req = '0;
        wait_drain(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL split_drain: got timeout want 3 bursts"); end
    endtask

    task automatic test_fairness();
        bit ok;
        int order[5];
        order = '{0, 1, 2, 3, 0};
        do_reset();
        eng_lat = 1;
        for (int i = 0; i < 4; i++) set_desc(i, 32'h1000 * i, 32'h8000 + 32'h100 * i, 16'd2);
        for (int k = 0; k < 5; k++)
            push_xfer(order[k], 32'h1000 * order[k], 32'h8000 + 32'h100 * order[k], 2, 1'b0);
        ch_req = 4'b1111;
        wait_acks(200, ok);
        ch_req = '0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL fair_acks: got timeout want 5 grants"); end
        wait_drain(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL fair_drain: got timeout want completion"); end
    endtask

    task automatic test_zero_len();
        bit ok;
        int valid_seen;
        valid_seen = 0;
        do_reset();
        set_desc(2, 32'h300, 32'h400, 16'd0);
        push_xfer(2, 32'h300, 32'h400, 0, 1'b0);
        ch_req = 4'b0100;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock);
            #1;
            ch_req = '0;
            if (eng_if.eng_valid) valid_seen++;
        end
        n_checks++;
        if (valid_seen != 0) begin
            n_fail++;
            $display("FAIL zero_len_valid: got %0d valid cycles want 0", valid_seen);
        end
        wait_drain(20, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL zero_len_drain: got timeout want ack+done"); end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        eng_if.eng_ready = 1'b0;
        set_desc(3, 32'h300, 32'h400, 16'd5);
        push_xfer(3, 32'h300, 32'h400, 5, 1'b0);
        ch_req = 4'b1000;
        @(posedge clock);
        #1;
        ch_req = '0;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (eng_if.eng_valid !== 1'b1 || eng_if.eng_src !== 32'h300 ||
                eng_if.eng_dst !== 32'h400 || eng_if.eng_beats !== 5'd5) begin
                n_fail++;
                $display("FAIL bp_stable[%0d]: got v=%b src=%h dst=%h beats=%0d want 1/300/400/5",
                         k, eng_if.eng_valid, eng_if.eng_src, eng_if.eng_dst, eng_if.eng_beats);
            end
            @(posedge clock);
            #1;
        end
        eng_if.eng_ready = 1'b1;
        wait_drain(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_drain: got timeout want completion"); end
    endtask

    task automatic test_max_len();
        bit ok;
        do_reset();
        set_desc(1, 32'hFFFF_FFF0, 32'h0000_8000, 16'hFFFF);
        push_xfer(1, 32'hFFFF_FFF0, 32'h0000_8000, 32'hFFFF, 1'b0);
        ch_req = 4'b0010;
        @(posedge clock);
        #1;
        ch_req = '0;
        wait_drain(12000, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL max_len_drain: got timeout want 4096 bursts"); end
    endtask

`ifdef DMA_SCHED_ERR_EN
    task automatic test_err_abort();
        bit ok;
        int valid_seen;
        valid_seen = 0;
        do_reset();
        eng_lat = 2;
        err_inject = 1'b1;
        set_desc(1, 32'h40, 32'h80, 16'd40);
        push_xfer(1, 32'h40, 32'h80, 40, 1'b1);
        ch_req = 4'b0010;
        @(posedge clock);
        #1;
        ch_req = '0;
        wait_drain(50, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL err_drain: got timeout want abort"); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            if (eng_if.eng_valid) valid_seen++;
        end
        n_checks++;
        if (valid_seen != 0) begin
            n_fail++;
            $display("FAIL err_no_more_bursts: got %0d valid cycles want 0", valid_seen);
        end
    endtask
`endif

    task automatic test_reset_mid();
        int done_seen, valid_seen;
        done_seen = 0;
        valid_seen = 0;
        do_reset();
        eng_lat = 8;
        set_desc(0, 32'h0, 32'h5000, 16'd40);
        exp_ack.push_back(0);
        exp_cmd.push_back('{src: 32'h0, dst: 32'h5000, beats: 5'd16});
        ch_req = 4'b0001;
        @(posedge clock);
        #1;
        ch_req = '0;
        repeat (2) @(posedge clock);
        #1;
        n_checks++;
        if (busy !== 1'b1 || eng_if.eng_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_in_wait: got busy=%b valid=%b want 1/0", busy, eng_if.eng_valid);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        n_checks++;
        if ({ch_ack, ch_done, eng_if.eng_valid, busy, eng_if.eng_src, eng_if.eng_dst,
             eng_if.eng_beats} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got ack=%b done=%b valid=%b busy=%b src=%h beats=%0d want 0",
                     ch_ack, ch_done, eng_if.eng_valid, busy, eng_if.eng_src, eng_if.eng_beats);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (ch_done != '0) done_seen++;
            if (eng_if.eng_valid) valid_seen++;
        end
        n_checks++;
        if (done_seen != 0 || valid_seen != 0) begin
            n_fail++;
            $display("FAIL mid_no_done: got done=%0d valid=%0d cycles want 0/0", done_seen, valid_seen);
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_split();
        test_fairness();
        test_zero_len();
        test_backpressure();
        test_max_len();
`ifdef DMA_SCHED_ERR_EN
        test_err_abort();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
